apb_master_ctrl: RTL and testbench

APB-domain sequencer of the ICB-to-APB bridge, sitting directly downstream of the command async FIFO and upstream of the response async FIFO. It pops one command word per transfer from the command FIFO read port and runs a two-phase APB3/APB4 transfer (SETUP, ACCESS). It then pushes a {error, read data} word into the response FIFO write port. A watchdog ends transfers whose slave never asserts pready and reports them as errors.

---
 rtl/icb2apb_pkg.sv | 14 +
 rtl/apb_watchdog.sv | 19 +
 rtl/apb_master_ctrl.sv | 83 ++++++++
 tb/tb_apb_master_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/icb2apb_pkg.sv
// icb2apb_pkg: shared widths, command/response field positions and APB sequencer states
package icb2apb_pkg;
  localparam int APB_ADDR_W    = 32;
  localparam int APB_DATA_W    = 32;
  localparam int APB_STRB_W    = APB_DATA_W / 8;
  localparam int CMD_W         = 1 + APB_STRB_W + APB_ADDR_W + APB_DATA_W;
  localparam int RSP_W         = APB_DATA_W + 1;
  localparam int CMD_WDATA_LSB = 0;
  localparam int CMD_ADDR_LSB  = CMD_WDATA_LSB + APB_DATA_W;
  localparam int CMD_STRB_LSB  = CMD_ADDR_LSB + APB_ADDR_W;
  localparam int CMD_WRITE_BIT = CMD_STRB_LSB + APB_STRB_W;
  localparam int RSP_ERR_BIT   = APB_DATA_W;
  typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_SETUP, ST_ACCESS, ST_RESP} apb_state_e;
endpackage

// File: rtl/apb_watchdog.sv
// apb_watchdog: counts stalled ACCESS cycles and flags the last one allowed
module apb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign expire = cnt_q == CW'(TIMEOUT - 1);
endmodule

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: pops one command per APB transfer, runs SETUP/ACCESS, pushes {err, rdata}
module apb_master_ctrl
  import icb2apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_W,
  parameter int DATA_WIDTH = APB_DATA_W,
  parameter int CMD_WIDTH  = 1 + DATA_WIDTH / 8 + ADDR_WIDTH + DATA_WIDTH,
  parameter int RSP_WIDTH  = DATA_WIDTH + 1,
  parameter int TIMEOUT    = 16
) (
  input  logic                    pclk,
  input  logic                    prst,
  input  logic                    cmd_empty,
  output logic                    cmd_ren,
  input  logic [CMD_WIDTH-1:0]    cmd_data,
  input  logic                    rsp_full,
  output logic                    rsp_wen,
  output logic [RSP_WIDTH-1:0]    rsp_data,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);
  apb_state_e           state_q, state_d;
  logic [CMD_WIDTH-1:0] cmd_q, cmd_d;
  logic [RSP_WIDTH-1:0] rsp_q, rsp_d;
  logic                 wd_expire;
  logic                 cmd_write;
  assign cmd_write = cmd_q[CMD_WRITE_BIT];
  apb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk   (pclk),
    .rst   (prst),
    .clr   (state_q == ST_SETUP),
    .en    (state_q == ST_ACCESS && !pready),
    .expire(wd_expire)
  );
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    rsp_d   = rsp_q;
    case (state_q)
      ST_IDLE:  state_d = cmd_empty ? ST_IDLE : ST_FETCH;
      ST_FETCH: begin
        cmd_d   = cmd_data;
        state_d = ST_SETUP;
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: if (pready || wd_expire) begin
        // a late pready on the expiring cycle still completes normally
        rsp_d[RSP_ERR_BIT]      = pready ? pslverr : 1'b1;
        rsp_d[DATA_WIDTH-1:0]   = (pready && !cmd_write) ? prdata : '0;
        state_d                 = ST_RESP;
      end
      ST_RESP:  state_d = rsp_full ? ST_RESP : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rsp_q   <= rsp_d;
    end
  end
  assign cmd_ren  = state_q == ST_IDLE && !cmd_empty;
  assign psel     = state_q == ST_SETUP || state_q == ST_ACCESS;
  assign penable  = state_q == ST_ACCESS;
  assign pwrite   = cmd_write;
  assign paddr    = cmd_q[CMD_ADDR_LSB +: ADDR_WIDTH];
  assign pwdata   = cmd_q[CMD_WDATA_LSB +: DATA_WIDTH];
  assign pstrb    = cmd_write ? cmd_q[CMD_STRB_LSB +: DATA_WIDTH/8] : '0;
  assign rsp_wen  = state_q == ST_RESP && !rsp_full;
  assign rsp_data = rsp_q;
endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: table-driven transfers plus stall and mid-transfer reset sequences
module tb_apb_master_ctrl;
  import icb2apb_pkg::*;
  logic pclk = 0, prst = 1, cmd_empty = 1, rsp_full = 0, pready = 0, pslverr = 0;
  logic [CMD_W-1:0] cmd_data = '0;
  logic [APB_DATA_W-1:0] prdata = '0;
  logic cmd_ren, rsp_wen, psel, penable, pwrite;
  logic [RSP_W-1:0] rsp_data;
  logic [APB_ADDR_W-1:0] paddr;
  logic [APB_DATA_W-1:0] pwdata;
  logic [APB_STRB_W-1:0] pstrb;

  apb_master_ctrl #(.TIMEOUT(16)) dut (
    .pclk(pclk), .prst(prst), .cmd_empty(cmd_empty), .cmd_ren(cmd_ren), .cmd_data(cmd_data),
    .rsp_full(rsp_full), .rsp_wen(rsp_wen), .rsp_data(rsp_data),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [CMD_W-1:0] cmd;
    int               waits;
    logic [31:0]      rd;
    logic             err;
    logic [32:0]      exp_rsp;
    int               exp_pen;
  } vec_t;

  int ntests = 0, nfail = 0;
  int cyc = 0, pops = 0, acc_n = 0, wait_n = 0, stab_err = 0;
  bit pend = 0;
  logic [CMD_W-1:0] cmdq[$];
  logic [32:0] rsp_log[$];
  int rsp_cyc[$], ren_log[$];
  int setup_cyc = 0, pen_first = 0, pen_cnt = 0;
  logic [31:0] s_paddr, s_pwdata;
  logic [3:0] s_pstrb;
  logic s_pwrite;

  // command FIFO, APB slave and bus monitor, all stepped from one clocked loop
  initial forever begin
    @(posedge pclk);
    cyc++;
    #1;
    if (pend) begin cmd_data = cmdq.pop_front(); pops++; pend = 0; end
    cmd_empty = (cmdq.size() == 0);
    if (penable === 1'b1) begin pready = (acc_n == wait_n); acc_n++; end
    else begin pready = 0; acc_n = 0; end
    #3;
    if (psel === 1'b1 && penable === 1'b0) begin
      setup_cyc = cyc; pen_cnt = 0;
      s_paddr = paddr; s_pwdata = pwdata; s_pstrb = pstrb; s_pwrite = pwrite;
    end
    if (penable === 1'b1) begin if (pen_cnt == 0) pen_first = cyc; pen_cnt++; end
    if ((psel === 1'b1 || rsp_wen === 1'b1) && {paddr, pwdata, pstrb, pwrite} !== {s_paddr, s_pwdata, s_pstrb, s_pwrite})
      stab_err++;
    if (rsp_wen === 1'b1) begin rsp_log.push_back(rsp_data); rsp_cyc.push_back(cyc); end
    if (cmd_ren === 1'b1) begin ren_log.push_back(cyc); pend = 1; end
  end

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [CMD_W-1:0] mk(logic w, logic [3:0] s, logic [31:0] a, logic [31:0] d);
    return {w, s, a, d};
  endfunction

  task automatic tick();
    @(posedge pclk);
    #3;
  endtask

  task automatic do_xfer(input vec_t v, input int idx);
    int n0 = rsp_log.size();
    int r0 = ren_log.size();
    int p0 = pops;
    int ren;
    wait_n = v.waits; prdata = v.rd; pslverr = v.err;
    cmdq.push_back(v.cmd);
    for (int i = 0; i < 300 && rsp_log.size() == n0; i++) tick();
    if (rsp_log.size() == n0 || ren_log.size() == r0) begin
      chk($sformatf("v%0d_done", idx), 0, 1);
      return;
    end
    ren = ren_log[r0];
    chk($sformatf("v%0d_rsp", idx), rsp_log[n0], v.exp_rsp);
    chk($sformatf("v%0d_pen_cycles", idx), pen_cnt, v.exp_pen);
    chk($sformatf("v%0d_paddr", idx), s_paddr, v.cmd[CMD_ADDR_LSB +: 32]);
    chk($sformatf("v%0d_pwdata", idx), s_pwdata, v.cmd[CMD_WDATA_LSB +: 32]);
    chk($sformatf("v%0d_pstrb", idx), s_pstrb, v.cmd[CMD_WRITE_BIT] ? v.cmd[CMD_STRB_LSB +: 4] : 4'h0);
    chk($sformatf("v%0d_pwrite", idx), s_pwrite, v.cmd[CMD_WRITE_BIT]);
    chk($sformatf("v%0d_setup_lat", idx), setup_cyc - ren, 2);
    chk($sformatf("v%0d_pen_lat", idx), pen_first - setup_cyc, 1);
    chk($sformatf("v%0d_rsp_lat", idx), rsp_cyc[n0] - pen_first, v.exp_pen);
    chk($sformatf("v%0d_pops", idx), pops - p0, 1);
    chk($sformatf("v%0d_stable", idx), stab_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    vec_t vecs[6];
    int n0, r0, p0, hold_bad;
    logic [31:0] pa;
    vecs[0] = '{mk(1, 4'hF, 32'h1000_0010, 32'hDEAD_BEEF), 0,    32'hAAAA_5555, 0, 33'h0_0000_0000, 1};
    vecs[1] = '{mk(0, 4'hF, 32'h2000_0004, 32'h1111_1111), 3,    32'h1234_5678, 0, 33'h0_1234_5678, 4};
    vecs[2] = '{mk(0, 4'h3, 32'h3000_0000, 32'h0000_0000), 1,    32'hFFFF_FFFF, 1, 33'h1_FFFF_FFFF, 2};
    vecs[3] = '{mk(1, 4'h5, 32'h4000_0008, 32'h0BAD_F00D), 2,    32'h5555_AAAA, 1, 33'h1_0000_0000, 3};
    vecs[4] = '{mk(0, 4'hC, 32'h5000_00FC, 32'h0000_0000), 15,   32'hCAFE_BABE, 0, 33'h0_CAFE_BABE, 16};
    vecs[5] = '{mk(0, 4'hF, 32'h6000_0000, 32'h0000_0000), 1000, 32'h7777_7777, 0, 33'h1_0000_0000, 16};

    repeat (3) tick();
    chk("reset_ctl", {psel, penable, pwrite, cmd_ren, rsp_wen}, 0);
    chk("reset_paddr", paddr, 0);
    chk("reset_pwdata", pwdata, 0);
    chk("reset_pstrb", pstrb, 0);
    chk("reset_rsp", rsp_data, 0);
    prst = 0;
    tick();

    for (int v = 0; v < 6; v++) do_xfer(vecs[v], v);
    tick();
    chk("timeout_idle", {psel, penable, rsp_wen}, 0);

    // two queued reads with the response FIFO full
    rsp_full = 1; wait_n = 0; prdata = 32'hA5A5_0F0F; pslverr = 0;
    n0 = rsp_log.size(); r0 = ren_log.size(); p0 = pops;
    cmdq.push_back(mk(0, 4'hF, 32'h7000_0000, 32'h0));
    cmdq.push_back(mk(0, 4'h1, 32'h7000_0100, 32'h0));
    for (int i = 0; i < 50 && penable !== 1'b1; i++) tick();
    chk("bp_access", penable, 1);
    tick();
    pa = paddr;
    chk("bp_paddr", pa, 32'h7000_0000);
    hold_bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (rsp_wen !== 1'b0 || rsp_data !== 33'h0_A5A5_0F0F || paddr !== pa || cmd_ren !== 1'b0) hold_bad++;
      tick();
    end
    chk("bp_hold", hold_bad, 0);
    rsp_full = 0;
    for (int i = 0; i < 100 && rsp_log.size() < n0 + 2; i++) tick();
    chk("bp_rsp_count", rsp_log.size() - n0, 2);
    chk("bp_ren_count", ren_log.size() - r0, 2);
    chk("bp_pops", pops - p0, 2);
    if (rsp_log.size() >= n0 + 2 && ren_log.size() >= r0 + 2) begin
      chk("bp_rsp0", rsp_log[n0], 33'h0_A5A5_0F0F);
      chk("bp_rsp1", rsp_log[n0 + 1], 33'h0_A5A5_0F0F);
      chk("bp_ren_gap", ren_log[r0 + 1] - rsp_cyc[n0], 1);
      chk("bp_paddr1", s_paddr, 32'h7000_0100);
    end

    // reset while waiting in ACCESS
    wait_n = 5; prdata = 32'h1357_9BDF; pslverr = 0;
    n0 = rsp_log.size(); p0 = pops;
    cmdq.push_back(mk(0, 4'hF, 32'h8000_0000, 32'h0));
    for (int i = 0; i < 50 && penable !== 1'b1; i++) tick();
    chk("rst_access", penable, 1);
    tick();
    prst = 1;
    tick();
    prst = 0;
    chk("rst_psel", {psel, penable}, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_rsp", rsp_data, 0);
    repeat (20) tick();
    chk("rst_no_rsp", rsp_log.size() - n0, 0);
    chk("rst_pops", pops - p0, 1);
    do_xfer('{mk(1, 4'h9, 32'h9000_0004, 32'hCAFE_F00D), 0, 32'h0, 0, 33'h0_0000_0000, 1}, 6);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
